// File: rtl/reg_arbiter.sv
// Round-robin arbiter giving four requesters one-at-a-time access to an
// external shared register. Each transaction runs IDLE -> ACCESS -> DONE.
module reg_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   wr,
   input  logic [NREQ*W-1:0] wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   ack,
   output logic [W-1:0]      rdata,
   input  logic [W-1:0]      reg_q,
   output logic [W-1:0]      reg_in,
   output logic              reg_en,
   output logic              reg_rst,
   output logic [7:0]        txn_cnt
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   last, last_nx;
   logic [IW-1:0]   win, win_nx;
   logic            win_wr, win_wr_nx;
   logic [NREQ-1:0] gnt_nx, ack_nx;
   logic [CW-1:0]   cnt_nx;
   logic [IW-1:0]   pick;
   logic            pick_ok;

   // Round-robin search starting one past the most recent winner.
   always_comb begin
      logic [IW-1:0] idx;
      pick    = '0;
      pick_ok = 1'b0;
      idx     = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx = IW'(last + IW'(i));
         if (!pick_ok && req[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   // Next-state and next registered-output logic.
   always_comb begin
      state_nx  = state;
      last_nx   = last;
      win_nx    = win;
      win_wr_nx = win_wr;
      gnt_nx    = '0;
      ack_nx    = '0;
      cnt_nx    = txn_cnt;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               state_nx  = ACCESS;
               last_nx   = pick;
               win_nx    = pick;
               win_wr_nx = wr[pick];
               gnt_nx    = NREQ'(1) << pick;
            end
         end
         ACCESS: begin
            state_nx = DONE;
            ack_nx   = NREQ'(1) << win;
         end
         DONE: begin
            state_nx = IDLE;
            cnt_nx   = txn_cnt + CW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         last    <= IW'(NREQ - 1);
         win     <= '0;
         win_wr  <= 1'b0;
         gnt     <= '0;
         ack     <= '0;
         txn_cnt <= '0;
      end else begin
         state   <= state_nx;
         last    <= last_nx;
         win     <= win_nx;
         win_wr  <= win_wr_nx;
         gnt     <= gnt_nx;
         ack     <= ack_nx;
         txn_cnt <= cnt_nx;
      end
   end

   // The shared register floats when disabled, so it is always enabled and
   // recirculates its own value except during a write access.
   assign reg_rst = rst;
   assign reg_en  = 1'b1;
   assign reg_in  = (state == ACCESS && win_wr && !rst) ? wdata[W*win +: W] : reg_q;
   assign rdata   = (|ack) ? reg_q : '0;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a behavioural shared register and
// grant/ack scoreboard queues filled at stimulus time.
module tb_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  wr = '0;
   logic [15:0] wdata = '0;
   logic [3:0]  gnt, ack, rdata, reg_q, reg_in;
   logic        reg_en, reg_rst;
   logic [7:0]  txn_cnt;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int prev_gnt_cyc = -1;
   bit chk_period = 1'b0;
   bit ack_seen   = 1'b0;

   logic [3:0] gq[$];
   logic [3:0] aq_ack[$];
   logic [3:0] aq_rdata[$];

   reg_arbiter #(.NREQ(4), .W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .rdata(rdata), .reg_q(reg_q),
      .reg_in(reg_in), .reg_en(reg_en), .reg_rst(reg_rst), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   // Shared register: loads Z when not enabled.
   always_ff @(posedge clk) begin
      if (reg_rst)     reg_q <= 4'b0000;
      else if (reg_en) reg_q <= reg_in;
      else             reg_q <= 4'bzzzz;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and check whatever the DUT presents.
   task automatic step();
      logic [3:0] e_ack, e_rd;
      @(negedge clk);
      cyc++;
      chk("reg_en", 32'(reg_en), 32'd1);
      if (gnt !== 4'b0000) begin
         chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
         if (gq.size() != 0) chk("gnt", 32'(gnt), 32'(gq.pop_front()));
         if (chk_period && prev_gnt_cyc >= 0) chk("gnt_period", 32'(cyc - prev_gnt_cyc), 32'd3);
         prev_gnt_cyc = cyc;
      end
      if (ack !== 4'b0000) begin
         ack_seen = 1'b1;
         chk("gnt_ack_excl", 32'(gnt), 32'd0);
         chk("ack_expected", 32'(aq_ack.size() != 0), 32'd1);
         if (aq_ack.size() != 0) begin
            e_ack = aq_ack.pop_front();
            e_rd  = aq_rdata.pop_front();
            chk("ack", 32'(ack), 32'(e_ack));
            chk("rdata", 32'(rdata), 32'(e_rd));
         end
      end else begin
         chk("rdata_idle", 32'(rdata), 32'd0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; wr = '0;
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_txn", 32'(txn_cnt), 32'd0);
      chk("rst_reg_q", 32'(reg_q), 32'd0);
      chk("rst_reg_rst", 32'(reg_rst), 32'd1);
      rst = 1'b0;
      step();
      chk("reg_rst_low", 32'(reg_rst), 32'd0);
   endtask

   task automatic run_txn(input int idx, input logic w, input logic [3:0] val,
                          input logic [3:0] exp_rd);
      logic [3:0] oh;
      oh = 4'(1 << idx);
      req = oh;
      wr  = w ? oh : 4'b0000;
      wdata = '0;
      wdata[4*idx +: 4] = val;
      gq.push_back(oh);
      aq_ack.push_back(oh);
      aq_rdata.push_back(exp_rd);
      ack_seen = 1'b0;
      for (int k = 0; k < 10 && !ack_seen; k++) step();
      chk("txn_done", 32'(ack_seen), 32'd1);
      req = '0; wr = '0;
      step();
   endtask

   initial begin
      // Reset, then requester 0 writes 1010 and sees it back on ack.
      do_reset();
      run_txn(0, 1'b1, 4'b1010, 4'b1010);
      chk("txn_cnt_1", 32'(txn_cnt), 32'd1);

      // All four reading continuously: strict rotation 0,1,2,3,0.
      do_reset();
      req = 4'b1111; wr = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         gq.push_back(4'(1 << (i % 4)));
         aq_ack.push_back(4'(1 << (i % 4)));
         aq_rdata.push_back(4'b0000);
      end
      chk_period = 1'b1; prev_gnt_cyc = -1;
      for (int i = 0; i < 14; i++) step();
      chk_period = 1'b0;
      req = '0;
      step();
      chk("rr_txn_cnt", 32'(txn_cnt), 32'd5);
      chk("rr_all_served", 32'(gq.size() + aq_ack.size()), 32'd0);

      // Write by requester 2 is visible to a later read by requester 1.
      run_txn(2, 1'b1, 4'b0110, 4'b0110);
      run_txn(1, 1'b0, 4'b1111, 4'b0110);
      chk("read_no_modify", 32'(reg_q), 32'b0110);

      // Register holds its value across idle cycles.
      run_txn(3, 1'b1, 4'b1100, 4'b1100);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_hold", 32'(reg_q), 32'b1100);
      end

      // Reset during write ACCESS aborts the transaction.
      req = 4'b0001; wr = 4'b0001; wdata = 16'h0007;
      gq.push_back(4'b0001);
      step();
      chk("abort_gnt", 32'(gnt), 32'b0001);
      rst = 1'b1; req = '0; wr = '0;
      step();
      chk("abort_reg_rst", 32'(reg_rst), 32'd1);
      rst = 1'b0;
      step();
      step();
      chk("abort_reg_q", 32'(reg_q), 32'd0);
      chk("abort_txn", 32'(txn_cnt), 32'd0);
      chk("abort_gnt_idle", 32'(gnt), 32'd0);
      chk("abort_no_ack", 32'(aq_ack.size()), 32'd0);

      // 256 transactions from reset wrap the counter to 0.
      do_reset();
      req = 4'b0001; wr = 4'b0000;
      for (int i = 0; i < 256; i++) begin
         gq.push_back(4'b0001);
         aq_ack.push_back(4'b0001);
         aq_rdata.push_back(4'b0000);
      end
      for (int i = 0; i < 765; i++) step();
      chk("txn_cnt_255", 32'(txn_cnt), 32'd255);
      step();
      step();
      req = '0;
      step();
      chk("txn_cnt_wrap", 32'(txn_cnt), 32'd0);
      chk("queues_empty", 32'(gq.size() + aq_ack.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters (fixed; only 4 supported).
REQ-002 Parameter: W, 4, data width of the shared register.
REQ-003 Clock and reset: clock clk; reset rst, synchronous, active-high.
REQ-004 Port: clk  in  1  clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: req  in  4  per-requester access request; held high until matching ack.
REQ-007 Port: wr  in  4  per-requester op: 1 = write, 0 = read; sampled with req.
REQ-008 Port: wdata  in  16  packed write data; requester i owns bits [4i+3:4i].
REQ-009 Port: gnt  out  4  one-hot grant; high during ACCESS for the winner.
REQ-010 Port: ack  out  4  one-hot completion pulse; one cycle, DONE state.
REQ-011 Port: rdata  out  4  shared register value; valid only while any ack bit is high, else 0.
REQ-012 Port: reg_q  in  4  Q output of shared 4-bit register.
REQ-013 Port: reg_in  out  4  data to shared register input.
REQ-014 Port: reg_en  out  1  enable to shared register.
REQ-015 Port: reg_rst  out  1  reset to shared register.
REQ-016 Port: txn_cnt  out  8  count of completed transactions.

Function
REQ-017 FSM states IDLE, ACCESS, DONE; IDLE -> ACCESS when any req bit high; ACCESS -> DONE always; DONE -> IDLE always.
REQ-018 Winner selected in IDLE only by round-robin, search starting at (last+1) mod 4; last updated to winner on IDLE -> ACCESS.
REQ-019 Winner index and its wr bit latched on IDLE -> ACCESS; req/wr/wdata changes after that do not alter the transaction.
REQ-020 ACCESS: gnt[winner]=1; if latched wr=1, reg_in = wdata slice of winner (sampled in ACCESS), else reg_in = reg_q.
REQ-021 reg_en SHALL be 1 in every cycle after reset (the shared register loads Z when disabled); reads/holds use reg_in = reg_q.
REQ-022 All states other than write-ACCESS: reg_in = reg_q.
REQ-023 DONE: ack[winner]=1, rdata = reg_q (reflects write made in ACCESS); gnt = 0.
REQ-024 txn_cnt increments by 1 on DONE -> IDLE; wraps 255 -> 0.
REQ-025 Request dropped during ACCESS/DONE: transaction still completes, ack still pulses.
REQ-026 Minimum transaction 3 cycles (IDLE, ACCESS, DONE); at most one transaction in flight.
REQ-027 gnt and ack each one-hot or zero; never both nonzero in one cycle.

Reset
REQ-028 rst high: next state IDLE, last = 3 (requester 0 highest priority first), txn_cnt = 0, gnt = 0, ack = 0, rdata = 0.
REQ-029 reg_rst = rst combinationally; reg_en = 1 while rst is high so the shared register clears to 0000.
REQ-030 rst during ACCESS or DONE aborts: no ack issued, no txn_cnt increment, write-ACCESS cycle with rst high does not write wdata.

Verification
REQ-031 rst 1 cycle, then req=0001, wr=0001, wdata[3:0]=1010 -> gnt=0001 in ACCESS, ack=0001 next cycle with rdata=1010, txn_cnt=1.
REQ-032 req=1111 held, all reads -> grants in order 0,1,2,3,0 every 3 cycles; no requester starved.
REQ-033 Requester 2 writes 0110, then requester 1 reads -> requester 1 ack with rdata=0110; register unchanged by read.
REQ-034 Idle 10 cycles after write 1100 -> reg_en=1 every cycle, reg_q stays 1100 (never Z).
REQ-035 rst asserted in ACCESS of a write 0111 -> no ack, reg_q=0000, txn_cnt=0, state IDLE.
REQ-036 256 completed transactions from reset -> txn_cnt=0 after the last.
